// File: rtl/food_map_port_ctrl_pkg.sv
// food_map_port_ctrl_pkg: food map geometry shared with the renderer and index mapping
package food_map_port_ctrl_pkg;
  localparam int ROWS = 64;
  localparam int COLS = 80;
  localparam int AW = $clog2(ROWS);
  localparam int CW = 7;
  localparam int CNTW = 13;
endpackage

// File: rtl/food_row_popcount.sv
// food_row_popcount: number of pellets set in one food map row
module food_row_popcount
  import food_map_port_ctrl_pkg::*;
(
  input  logic [COLS-1:0] row,
  output logic [CNTW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < COLS; i++) cnt = cnt + CNTW'(row[i]);
  end
endmodule

// File: rtl/food_map_port_ctrl.sv
// food_map_port_ctrl: port A owner of the food map, arbitrating level refill against pellet eats
module food_map_port_ctrl
  import food_map_port_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            refill_req,
  output logic            refill_busy,
  output logic            refill_done,
  input  logic            eat_req,
  input  logic [CW-1:0]   eat_x,
  input  logic [AW-1:0]   eat_y,
  output logic            eat_ack,
  output logic            eat_hit,
  output logic [AW-1:0]   rom_addr,
  input  logic [COLS-1:0] rom_data,
  output logic [AW-1:0]   ram_addra,
  output logic            ram_wea,
  output logic [COLS-1:0] ram_dina,
  input  logic [COLS-1:0] ram_douta,
  output logic [CNTW-1:0] food_left,
  output logic            level_clear
);
  typedef enum logic [2:0] {IDLE, EAT_RD, EAT_CHK, EAT_WR, REF_RUN, REF_LAST} state_t;
  state_t state, state_n;
  logic [CW-1:0] ex, ex_n;
  logic pend, pend_n, loaded, loaded_n, busy_n, done_n, ack_n, hit_n, wea_n, clear_n, hit;
  logic [AW-1:0] rom_addr_n, addra_n;
  logic [COLS-1:0] dina_n;
  logic [CNTW-1:0] left_n, pc;
  food_row_popcount u_pc (.row(rom_data), .cnt(pc));
  always_comb begin
    state_n = state;
    ex_n = ex;
    pend_n = pend | (refill_req & (state == EAT_RD || state == EAT_CHK || state == EAT_WR));
    loaded_n = loaded;
    busy_n = refill_busy;
    done_n = 1'b0;
    ack_n = 1'b0;
    hit_n = 1'b0;
    wea_n = 1'b0;
    rom_addr_n = rom_addr;
    addra_n = ram_addra;
    dina_n = ram_dina;
    left_n = food_left;
    hit = (ex < CW'(COLS)) && ram_douta[ex];
    case (state)
      IDLE:
        if (refill_req || pend) begin
          state_n = REF_RUN;
          pend_n = 1'b0;
          busy_n = 1'b1;
          left_n = '0;
          rom_addr_n = '0;
        end else if (eat_req) begin
          state_n = EAT_RD;
          ex_n = eat_x;
          addra_n = eat_y;
        end
      EAT_RD: state_n = EAT_CHK;
      EAT_CHK: begin
        state_n = EAT_WR;
        ack_n = 1'b1;
        hit_n = hit;
        wea_n = hit;
        dina_n = ram_douta & ~(COLS'(1) << ex);
        left_n = (hit && food_left != '0) ? food_left - 1'b1 : food_left;
      end
      EAT_WR: state_n = IDLE;
      // rom_data lags rom_addr by one cycle, so the row being written is rom_addr-1
      REF_RUN: begin
        state_n = (rom_addr == AW'(ROWS - 1)) ? REF_LAST : REF_RUN;
        rom_addr_n = (rom_addr == AW'(ROWS - 1)) ? rom_addr : rom_addr + 1'b1;
        if (rom_addr != '0) begin
          wea_n = 1'b1;
          addra_n = rom_addr - 1'b1;
          dina_n = rom_data;
          left_n = food_left + pc;
        end
      end
      REF_LAST: begin
        state_n = IDLE;
        wea_n = 1'b1;
        addra_n = rom_addr;
        dina_n = rom_data;
        left_n = food_left + pc;
        done_n = 1'b1;
        busy_n = 1'b0;
        loaded_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    clear_n = loaded_n && left_n == '0 && !busy_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ex <= '0;
      pend <= 1'b0;
      loaded <= 1'b0;
      refill_busy <= 1'b0;
      refill_done <= 1'b0;
      eat_ack <= 1'b0;
      eat_hit <= 1'b0;
      rom_addr <= '0;
      ram_addra <= '0;
      ram_wea <= 1'b0;
      ram_dina <= '0;
      food_left <= '0;
      level_clear <= 1'b0;
    end else begin
      state <= state_n;
      ex <= ex_n;
      pend <= pend_n;
      loaded <= loaded_n;
      refill_busy <= busy_n;
      refill_done <= done_n;
      eat_ack <= ack_n;
      eat_hit <= hit_n;
      rom_addr <= rom_addr_n;
      ram_addra <= addra_n;
      ram_wea <= wea_n;
      ram_dina <= dina_n;
      food_left <= left_n;
      level_clear <= clear_n;
    end
  end
endmodule

// File: tb/tb_food_map_port_ctrl.sv
// tb_food_map_port_ctrl: directed scenarios against a ROM model and a read-first port A RAM model
module tb_food_map_port_ctrl;
  import food_map_port_ctrl_pkg::*;
  logic clk = 0, rst = 1, refill_req = 0, eat_req = 0;
  logic [CW-1:0] eat_x = '0;
  logic [AW-1:0] eat_y = '0;
  logic refill_busy, refill_done, eat_ack, eat_hit, ram_wea, level_clear;
  logic [AW-1:0] rom_addr, ram_addra;
  logic [COLS-1:0] rom_data, ram_dina, ram_douta;
  logic [CNTW-1:0] food_left;
  logic [COLS-1:0] rom [ROWS];
  logic [COLS-1:0] mem [ROWS];
  int checks = 0, errors = 0, wr_cnt = 0;
  food_map_port_ctrl dut (
    .clk(clk), .rst(rst), .refill_req(refill_req), .refill_busy(refill_busy),
    .refill_done(refill_done), .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ack(eat_ack), .eat_hit(eat_hit), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .food_left(food_left), .level_clear(level_clear)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_douta <= mem[ram_addra];
  end
  always @(posedge clk) if (ram_wea) wr_cnt <= wr_cnt + 1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_refill(output int n);
    refill_req = 1;
    tick;
    refill_req = 0;
    n = 0;
    while (!refill_done && n < 200) begin
      tick;
      n++;
    end
  endtask
  task automatic do_eat(input int x, input int y, output int n, output logic h, output logic w,
                        output logic [COLS-1:0] d, output logic [CNTW-1:0] fl, output logic lc);
    eat_req = 1;
    eat_x = CW'(x);
    eat_y = AW'(y);
    n = 0;
    do begin
      tick;
      n++;
    end while (!eat_ack && n < 20);
    h = eat_hit;
    w = ram_wea;
    d = ram_dina;
    fl = food_left;
    lc = level_clear;
    eat_req = 0;
    tick;
  endtask
  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    checks++;
    if ({ram_wea, eat_ack, eat_hit, refill_busy, refill_done, level_clear} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {ram_wea, eat_ack, eat_hit, refill_busy, refill_done, level_clear});
    end
    checks++;
    if (food_left !== '0 || rom_addr !== '0 || ram_addra !== '0) begin
      errors++;
      $display("FAIL reset_regs food_left=%0d rom_addr=%0d ram_addra=%0d want 0", food_left, rom_addr, ram_addra);
    end
  endtask
  task automatic test_refill;
    int n, w0;
    w0 = wr_cnt;
    do_refill(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL refill_latency got %0d want 65", n); end
    checks++;
    if (food_left !== 13'd5) begin errors++; $display("FAIL refill_food_left got %0d want 5", food_left); end
    checks++;
    if (level_clear !== 1'b0 || refill_busy !== 1'b0) begin
      errors++;
      $display("FAIL refill_flags level_clear=%b busy=%b want 0 0", level_clear, refill_busy);
    end
    tick;
    checks++;
    if (mem[3] !== 80'h1F || mem[0] !== 80'h0 || mem[63] !== 80'h0) begin
      errors++;
      $display("FAIL refill_rows row3=%h row0=%h row63=%h want 1f 0 0", mem[3], mem[0], mem[63]);
    end
    checks++;
    if (wr_cnt - w0 !== 64) begin errors++; $display("FAIL refill_writes got %0d want 64", wr_cnt - w0); end
  endtask
  task automatic test_eat;
    int n;
    logic h, w, lc;
    logic [COLS-1:0] d;
    logic [CNTW-1:0] fl;
    do_eat(2, 3, n, h, w, d, fl, lc);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL eat_latency got %0d want 3", n); end
    checks++;
    if (h !== 1'b1 || w !== 1'b1 || d !== 80'h1B) begin
      errors++;
      $display("FAIL eat_hit hit=%b wea=%b dina=%h want 1 1 1b", h, w, d);
    end
    checks++;
    if (fl !== 13'd4) begin errors++; $display("FAIL eat_food_left got %0d want 4", fl); end
    checks++;
    if (mem[3] !== 80'h1B) begin errors++; $display("FAIL eat_row got %h want 1b", mem[3]); end
    do_eat(2, 3, n, h, w, d, fl, lc);
    checks++;
    if (h !== 1'b0 || w !== 1'b0 || fl !== 13'd4) begin
      errors++;
      $display("FAIL eat_repeat hit=%b wea=%b food_left=%0d want 0 0 4", h, w, fl);
    end
  endtask
  task automatic test_eat_oob;
    int n, w0;
    logic h, w, lc;
    logic [COLS-1:0] d;
    logic [CNTW-1:0] fl;
    w0 = wr_cnt;
    do_eat(85, 3, n, h, w, d, fl, lc);
    checks++;
    if (n !== 3 || h !== 1'b0 || w !== 1'b0 || fl !== 13'd4 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL eat_oob lat=%0d hit=%b wea=%b food_left=%0d writes=%0d want 3 0 0 4 0", n, h, w, fl, wr_cnt - w0);
    end
  endtask
  task automatic test_priority;
    int n;
    logic seen;
    refill_req = 1;
    eat_req = 1;
    eat_x = 0;
    eat_y = 3;
    tick;
    refill_req = 0;
    checks++;
    if (refill_busy !== 1'b1 || eat_ack !== 1'b0) begin
      errors++;
      $display("FAIL prio_refill_first busy=%b ack=%b want 1 0", refill_busy, eat_ack);
    end
    n = 0;
    seen = 0;
    while (!eat_ack && n < 200) begin
      tick;
      n++;
      if (refill_done) seen = 1;
    end
    checks++;
    if (n !== 68 || !seen || eat_hit !== 1'b1 || food_left !== 13'd4) begin
      errors++;
      $display("FAIL prio_eat_after lat=%0d done_seen=%b hit=%b food_left=%0d want 68 1 1 4", n, seen, eat_hit, food_left);
    end
    eat_req = 0;
    tick;
    eat_req = 1;
    eat_x = 1;
    eat_y = 3;
    tick;
    tick;
    refill_req = 1;
    tick;
    refill_req = 0;
    eat_req = 0;
    checks++;
    if (eat_ack !== 1'b1 || eat_hit !== 1'b1 || refill_busy !== 1'b0) begin
      errors++;
      $display("FAIL pend_eat_completes ack=%b hit=%b busy=%b want 1 1 0", eat_ack, eat_hit, refill_busy);
    end
    tick;
    tick;
    checks++;
    if (refill_busy !== 1'b1) begin errors++; $display("FAIL pend_refill_start busy=%b want 1", refill_busy); end
    n = 0;
    while (!refill_done && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 65 || food_left !== 13'd5) begin
      errors++;
      $display("FAIL pend_refill_done lat=%0d food_left=%0d want 65 5", n, food_left);
    end
    tick;
  endtask
  task automatic test_clear;
    int n;
    logic h, w, lc;
    logic [COLS-1:0] d;
    logic [CNTW-1:0] fl;
    for (int i = 0; i < 5; i++) begin
      do_eat(i, 3, n, h, w, d, fl, lc);
      checks++;
      if (h !== 1'b1 || fl !== CNTW'(4 - i)) begin
        errors++;
        $display("FAIL clear_eat%0d hit=%b food_left=%0d want 1 %0d", i, h, fl, 4 - i);
      end
    end
    checks++;
    if (lc !== 1'b1 || level_clear !== 1'b1) begin
      errors++;
      $display("FAIL level_clear got %b want 1", level_clear);
    end
    refill_req = 1;
    tick;
    refill_req = 0;
    checks++;
    if (level_clear !== 1'b0 || refill_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_drop level_clear=%b busy=%b want 0 1", level_clear, refill_busy);
    end
    n = 0;
    while (!refill_done && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 65 || food_left !== 13'd5 || level_clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_refill lat=%0d food_left=%0d level_clear=%b want 65 5 0", n, food_left, level_clear);
    end
    tick;
  endtask
  task automatic test_reset_abort;
    int n, w0;
    logic h, w, lc;
    logic [COLS-1:0] d;
    logic [CNTW-1:0] fl;
    eat_req = 1;
    eat_x = 0;
    eat_y = 3;
    tick;
    tick;
    rst = 1;
    eat_req = 0;
    tick;
    rst = 0;
    checks++;
    if (ram_wea !== 1'b0 || eat_ack !== 1'b0 || food_left !== '0 || refill_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_eat wea=%b ack=%b food_left=%0d busy=%b want 0 0 0 0", ram_wea, eat_ack, food_left, refill_busy);
    end
    w0 = wr_cnt;
    tick;
    tick;
    checks++;
    if (wr_cnt !== w0 || mem[3] !== 80'h1F) begin
      errors++;
      $display("FAIL rst_eat_nowrite writes=%0d row3=%h want 0 1f", wr_cnt - w0, mem[3]);
    end
    refill_req = 1;
    tick;
    refill_req = 0;
    repeat (20) tick;
    checks++;
    if (rom_addr !== AW'(20) || refill_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_refill rom_addr=%0d busy=%b want 20 1", rom_addr, refill_busy);
    end
    rst = 1;
    tick;
    rst = 0;
    checks++;
    if (ram_wea !== 1'b0 || refill_busy !== 1'b0 || food_left !== '0 || rom_addr !== '0 || refill_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_refill wea=%b busy=%b food_left=%0d rom_addr=%0d done=%b want 0 0 0 0 0",
               ram_wea, refill_busy, food_left, rom_addr, refill_done);
    end
    w0 = wr_cnt;
    tick;
    tick;
    checks++;
    if (wr_cnt !== w0) begin errors++; $display("FAIL rst_refill_nowrite writes=%0d want 0", wr_cnt - w0); end
    do_eat(0, 3, n, h, w, d, fl, lc);
    checks++;
    if (n !== 3 || h !== 1'b1 || w !== 1'b1 || fl !== '0 || lc !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_eat lat=%0d hit=%b wea=%b food_left=%0d level_clear=%b want 3 1 1 0 0", n, h, w, fl, lc);
    end
  endtask
  initial begin
    for (int i = 0; i < ROWS; i++) rom[i] = '0;
    rom[3] = 80'h1F;
    test_reset;
    test_refill;
    test_eat;
    test_eat_oob;
    test_priority;
    test_clear;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
